// File: rtl/dm9000a_pkg.sv
// dm9000a_pkg: shared types and constants for the DM9000A bus sequencer.
//   - state_e       : sequencer state enumeration
//   - CMD_INDEX/DATA: encodings of the chip CMD pin
//   - DEF_*_CYC     : default bus/reset timing, in clock cycles
//   - NCR..MWCMD    : commonly used DM9000A register indices
package dm9000a_pkg;

  typedef enum logic [3:0] {
    ST_RST_HOLD = 4'd0,
    ST_RST_WAIT = 4'd1,
    ST_IDLE     = 4'd2,
    ST_I_SETUP  = 4'd3,
    ST_I_STROBE = 4'd4,
    ST_I_HOLD   = 4'd5,
    ST_D_SETUP  = 4'd6,
    ST_D_STROBE = 4'd7,
    ST_D_HOLD   = 4'd8,
    ST_DONE     = 4'd9
  } state_e;

  localparam logic CMD_INDEX = 1'b0;
  localparam logic CMD_DATA  = 1'b1;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_RST_CYC    = 16;
  localparam int DEF_INIT_CYC   = 32;

  localparam logic [7:0] NCR   = 8'h00;
  localparam logic [7:0] NSR   = 8'h01;
  localparam logic [7:0] VID_L = 8'h28;
  localparam logic [7:0] PID_L = 8'h2A;
  localparam logic [7:0] ISR   = 8'hFE;
  localparam logic [7:0] MWCMD = 8'hF8;

  function automatic int max5(int a, int b, int c, int d, int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/dm9000a_bus_seq.sv
// dm9000a_bus_seq: turns one host register request into a DM9000A index
// write (CMD=0) followed by a data write or read (CMD=1), and generates the
// chip's power-up reset pulse plus settle time.
// Ports:
//   iCLK, iRST_N          clock, async active-low reset
//   iREQ/iWE/iREG/iWDATA  host request, taken only while oREADY=1
//   oREADY, oDONE, oRDATA host status and read data
//   oENET_*               chip pins (CS_N, CMD, WR_N, RD_N, RST_N, DOUT, OE)
//   iENET_DIN             sampled chip data bus
module dm9000a_bus_seq
  import dm9000a_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int INIT_CYC   = DEF_INIT_CYC
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ,
  input  logic        iWE,
  input  logic [7:0]  iREG,
  input  logic [15:0] iWDATA,
  output logic        oREADY,
  output logic        oDONE,
  output logic [15:0] oRDATA,
  output logic        oENET_CS_N,
  output logic        oENET_CMD,
  output logic        oENET_WR_N,
  output logic        oENET_RD_N,
  output logic        oENET_RST_N,
  output logic [15:0] oENET_DOUT,
  output logic        oENET_OE,
  input  logic [15:0] iENET_DIN
);

  localparam int MAX_CYC = max5(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC, INIT_CYC);
  localparam int CW      = $clog2(MAX_CYC + 1);
  typedef logic [CW-1:0] cnt_t;

  // Counter value loaded on entry to a timed state: the state then lasts
  // (load + 1) cycles, leaving when the counter reads zero.
  function automatic cnt_t load_val(state_e s);
    case (s)
      ST_RST_HOLD: return cnt_t'(RST_CYC - 1);
      ST_RST_WAIT: return cnt_t'(INIT_CYC - 1);
      ST_I_SETUP,
      ST_D_SETUP:  return cnt_t'(SETUP_CYC - 1);
      ST_I_STROBE,
      ST_D_STROBE: return cnt_t'(STROBE_CYC - 1);
      ST_I_HOLD,
      ST_D_HOLD:   return cnt_t'(HOLD_CYC - 1);
      default:     return '0;
    endcase
  endfunction

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        we_q;
  logic [7:0]  reg_q;
  logic [15:0] wdata_q;

  logic        ready_q, done_q, cs_n_q, cmd_q, wr_n_q, rd_n_q, rst_n_q, oe_q;
  logic [15:0] rdata_q, dout_q;

  logic        ready_d, done_d, cs_n_d, cmd_d, wr_n_d, rd_n_d, rst_n_d, oe_d;
  logic [15:0] rdata_d, dout_d;

  logic        accept;
  logic        we_n;
  logic [7:0]  reg_n;
  logic [15:0] wdata_n;
  logic        in_idx, in_dat;

  assign accept = (state_q == ST_IDLE) && iREQ;

  // Request fields as they will be held next cycle; outputs are built from
  // the next state, so the accept edge must already see the new request.
  assign we_n    = accept ? iWE    : we_q;
  assign reg_n   = accept ? iREG   : reg_q;
  assign wdata_n = accept ? iWDATA : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (iREQ) state_d = ST_I_SETUP;
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else begin
          case (state_q)
            ST_RST_HOLD: state_d = ST_RST_WAIT;
            ST_RST_WAIT: state_d = ST_IDLE;
            ST_I_SETUP:  state_d = ST_I_STROBE;
            ST_I_STROBE: state_d = ST_I_HOLD;
            ST_I_HOLD:   state_d = ST_D_SETUP;
            ST_D_SETUP:  state_d = ST_D_STROBE;
            ST_D_STROBE: state_d = ST_D_HOLD;
            ST_D_HOLD:   state_d = ST_DONE;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
    endcase
    if (state_d != state_q) cnt_d = load_val(state_d);
  end

  assign in_idx = (state_d == ST_I_SETUP) || (state_d == ST_I_STROBE) || (state_d == ST_I_HOLD);
  assign in_dat = (state_d == ST_D_SETUP) || (state_d == ST_D_STROBE) || (state_d == ST_D_HOLD);

  always_comb begin
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
    rst_n_d = (state_d != ST_RST_HOLD);
    cs_n_d  = !(in_idx || in_dat);
    cmd_d   = in_dat ? CMD_DATA : CMD_INDEX;
    // The strobe states are mutually exclusive, so RD_N and WR_N can never
    // be low together.
    wr_n_d  = !((state_d == ST_I_STROBE) || ((state_d == ST_D_STROBE) && we_n));
    rd_n_d  = !((state_d == ST_D_STROBE) && !we_n);
    oe_d    = in_idx || (in_dat && we_n);
    dout_d  = '0;
    if (in_idx)              dout_d = {8'h00, reg_n};
    else if (in_dat && we_n) dout_d = wdata_n;
    // Capture on the last strobe cycle, while RD_N is still low.
    rdata_d = rdata_q;
    if ((state_q == ST_D_STROBE) && (cnt_q == '0) && !we_q) rdata_d = iENET_DIN;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_RST_HOLD;
      cnt_q   <= load_val(ST_RST_HOLD);
      we_q    <= 1'b0;
      reg_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      cmd_q   <= CMD_INDEX;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      rst_n_q <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_n;
      reg_q   <= reg_n;
      wdata_q <= wdata_n;
      ready_q <= ready_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      cmd_q   <= cmd_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      rst_n_q <= rst_n_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  assign oREADY      = ready_q;
  assign oDONE       = done_q;
  assign oRDATA      = rdata_q;
  assign oENET_CS_N  = cs_n_q;
  assign oENET_CMD   = cmd_q;
  assign oENET_WR_N  = wr_n_q;
  assign oENET_RD_N  = rd_n_q;
  assign oENET_RST_N = rst_n_q;
  assign oENET_DOUT  = dout_q;
  assign oENET_OE    = oe_q;

endmodule

// File: tb/tb_dm9000a_bus_seq.sv
// Bench for dm9000a_bus_seq: a default-timing instance (dut) and a
// stretched-timing instance (dut2, SETUP=2 STROBE=4 HOLD=3).
// Edge numbering: the accept edge is edge 1 of an access.
module tb_dm9000a_bus_seq;
  import dm9000a_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst_n = 1'b1, req = 1'b0, we = 1'b0;
  logic [7:0]  rg = '0;
  logic [15:0] wd = '0, rdval = '0, din;
  logic        ready, done, cs_n, cmd, wr_n, rd_n, enrst_n, oe;
  logic [15:0] rdata, dout;
  // the chip drives the read value only while RD_N is low
  assign din = rd_n ? ~rdval : rdval;

  dm9000a_bus_seq dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .iWE(we), .iREG(rg), .iWDATA(wd),
    .oREADY(ready), .oDONE(done), .oRDATA(rdata), .oENET_CS_N(cs_n),
    .oENET_CMD(cmd), .oENET_WR_N(wr_n), .oENET_RD_N(rd_n),
    .oENET_RST_N(enrst_n), .oENET_DOUT(dout), .oENET_OE(oe), .iENET_DIN(din)
  );

  // stretched-timing instance
  logic        rst2_n = 1'b1, req2 = 1'b0, we2 = 1'b0;
  logic [7:0]  rg2 = '0;
  logic [15:0] wd2 = '0;
  logic [15:0] din2 = 16'h0000;
  logic        ready2, done2, cs2_n, cmd2, wr2_n, rd2_n, enrst2_n, oe2;
  logic [15:0] rdata2, dout2;

  dm9000a_bus_seq #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(3), .RST_CYC(2), .INIT_CYC(3)) dut2 (
    .iCLK(clk), .iRST_N(rst2_n), .iREQ(req2), .iWE(we2), .iREG(rg2), .iWDATA(wd2),
    .oREADY(ready2), .oDONE(done2), .oRDATA(rdata2), .oENET_CS_N(cs2_n),
    .oENET_CMD(cmd2), .oENET_WR_N(wr2_n), .oENET_RD_N(rd2_n),
    .oENET_RST_N(enrst2_n), .oENET_DOUT(dout2), .oENET_OE(oe2), .iENET_DIN(din2)
  );

  int total = 0, bad = 0;
  logic [15:0] exp_rd = '0;

  typedef struct packed {
    logic ready, done, cs_n, cmd, wr_n, rd_n, oe;
    logic [15:0] dout;
  } bus_t;

  typedef struct {
    logic w; logic [7:0] r; logic [15:0] wd; logic [15:0] rv; logic [15:0] exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Expected pins at edge k of an access, from the phase arithmetic:
  // edges 1..P index phase, P+1..2P data phase, 2P+1 done, then ready.
  function automatic bus_t model(int S, int T, int H, logic w, logic [7:0] r,
                                 logic [15:0] wdat, int k);
    bus_t m;
    int P, o;
    P = S + T + H;
    m = '{ready: 1'b0, done: 1'b0, cs_n: 1'b1, cmd: 1'b0, wr_n: 1'b1,
          rd_n: 1'b1, oe: 1'b0, dout: 16'h0};
    if (k >= 1 && k <= P) begin
      o = k - 1;
      m.cs_n = 1'b0; m.oe = 1'b1; m.dout = {8'h00, r};
      if (o >= S && o < S + T) m.wr_n = 1'b0;
    end else if (k > P && k <= 2 * P) begin
      o = k - 1 - P;
      m.cs_n = 1'b0; m.cmd = 1'b1; m.oe = w;
      if (w) m.dout = wdat;
      if (o >= S && o < S + T) begin
        if (w) m.wr_n = 1'b0; else m.rd_n = 1'b0;
      end
    end else if (k == 2 * P + 1) begin
      m.done = 1'b1;
    end else if (k > 2 * P + 1) begin
      m.ready = 1'b1;
    end
    return m;
  endfunction

  // DOUT only matters while the driver is enabled
  function automatic bus_t obs1();
    return '{ready: ready, done: done, cs_n: cs_n, cmd: cmd, wr_n: wr_n,
             rd_n: rd_n, oe: oe, dout: oe ? dout : 16'h0};
  endfunction

  function automatic bus_t obs2();
    return '{ready: ready2, done: done2, cs_n: cs2_n, cmd: cmd2, wr_n: wr2_n,
             rd_n: rd2_n, oe: oe2, dout: oe2 ? dout2 : 16'h0};
  endfunction

  function automatic bus_t idle_pins(logic rdy);
    return '{ready: rdy, done: 1'b0, cs_n: 1'b1, cmd: 1'b0, wr_n: 1'b1,
             rd_n: 1'b1, oe: 1'b0, dout: 16'h0};
  endfunction

  // Called just after reset release, before the next edge.
  task automatic reset_seq(input string nm);
    for (int e = 1; e <= DEF_RST_CYC + DEF_INIT_CYC; e++) begin
      tick();
      chk({nm, "_rstpin"}, enrst_n, (e >= DEF_RST_CYC));
      chk({nm, "_pins"}, obs1(), idle_pins(e >= DEF_RST_CYC + DEF_INIT_CYC));
    end
  endtask

  // One access on dut, starting while ready=1. With noise set, iREQ and
  // the request fields wander while busy and must be ignored.
  task automatic access(input logic w, input logic [7:0] r, input logic [15:0] wdat,
                        input logic [15:0] rv, input bit noise, input string nm);
    logic [15:0] old_rd;
    old_rd = exp_rd;
    req = 1'b1; we = w; rg = r; wd = wdat; rdval = rv;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk({nm, "_bus"}, obs1(), model(1, 2, 1, w, r, wdat, k));
      if (k == 1) chk({nm, "_rd_before"}, rdata, old_rd);
      if (k == 9) begin
        if (!w) exp_rd = rv;
        chk({nm, "_rd_done"}, rdata, exp_rd);
      end
      if (k == 10) chk({nm, "_rd_held"}, rdata, exp_rd);
      if (noise && k < 9) begin
        req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        rg = 8'($urandom); wd = 16'($urandom);
      end else begin
        req = 1'b0;
      end
      if (k < 10) tick();
    end
  endtask

  vec_t tbl[6];

  initial begin
    int done_cnt, first_done, last_done, cs_falls, wr_low;
    int wl1, wl2, cs_low, done_edge;
    logic prev_cs;

    tbl[0] = '{w: 1'b1, r: 8'h1F,  wd: 16'h0000, rv: 16'h1234, exp_rdata: 16'h0000};
    tbl[1] = '{w: 1'b0, r: VID_L,  wd: 16'h0000, rv: 16'h0A46, exp_rdata: 16'h0A46};
    tbl[2] = '{w: 1'b1, r: NCR,    wd: 16'h0001, rv: 16'h5555, exp_rdata: 16'h0A46};
    tbl[3] = '{w: 1'b0, r: PID_L,  wd: 16'hFFFF, rv: 16'h9000, exp_rdata: 16'h9000};
    tbl[4] = '{w: 1'b1, r: MWCMD,  wd: 16'hFFFF, rv: 16'h0000, exp_rdata: 16'h9000};
    tbl[5] = '{w: 1'b0, r: ISR,    wd: 16'h0000, rv: 16'h0000, exp_rdata: 16'h0000};

    // power-up reset
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    tick(); tick();
    chk("rst_pins", obs1(), idle_pins(1'b0));
    chk("rst_dout", dout, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_enrst", enrst_n, 1'b0);
    #2 rst_n = 1'b1; rst2_n = 1'b1;
    req = 1'b1;  // requests during the reset sequence are ignored
    reset_seq("por");
    req = 1'b0;

    // table-driven accesses
    for (int i = 0; i < 6; i++) begin
      access(tbl[i].w, tbl[i].r, tbl[i].wd, tbl[i].rv, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
    end

    // iREQ held high: one access per 10 cycles
    done_cnt = 0; first_done = 0; last_done = 0; cs_falls = 0; wr_low = 0; prev_cs = 1'b1;
    req = 1'b1; we = 1'b1; rg = NSR; wd = 16'h00AA;
    tick();
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        last_done = k;
      end
      if (prev_cs && !cs_n) cs_falls++;
      prev_cs = cs_n;
      if (!wr_n) wr_low++;
      if (k == 30) req = 1'b0;
      if (k < 30) tick();
    end
    chk("b2b_done_cnt", done_cnt, 3);
    chk("b2b_first_done", first_done, 9);
    chk("b2b_last_done", last_done, 29);
    chk("b2b_cs_falls", cs_falls, 3);
    chk("b2b_wr_low", wr_low, 12);
    chk("b2b_ready", ready, 1'b1);
    chk("b2b_rdata", rdata, exp_rd);

    // randomized accesses with noisy inputs while busy
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      access(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 16'($urandom),
             1'b1, $sformatf("rnd%0d", i));
    end

    // abort a read in its data strobe
    access(1'b0, NSR, 16'h0, 16'hC0DE, 1'b0, "pre_abort");
    req = 1'b1; we = 1'b0; rg = VID_L; rdval = 16'h1111;
    tick();
    req = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    chk("abort_in_strobe", rd_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pins", obs1(), idle_pins(1'b0));
    chk("abort_rdata", rdata, 16'h0);
    chk("abort_enrst", enrst_n, 1'b0);
    #1 rst_n = 1'b1;
    exp_rd = '0;
    reset_seq("abort");
    chk("abort_rdata_after", rdata, 16'h0);

    // stretched timing on dut2
    for (int n = 0; n < 20 && !ready2; n++) tick();
    chk("dut2_ready", ready2, 1'b1);
    wl1 = 0; wl2 = 0; cs_low = 0; done_edge = 0;
    req2 = 1'b1; we2 = 1'b1; rg2 = 8'h3C; wd2 = 16'hBEEF;
    tick();
    req2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      chk("dut2_bus", obs2(), model(2, 4, 3, 1'b1, 8'h3C, 16'hBEEF, k));
      if (!wr2_n) begin
        if (k <= 9) wl1++; else wl2++;
      end
      if (!cs2_n) cs_low++;
      if (done2) done_edge = k;
      if (k < 20) tick();
    end
    chk("dut2_wr_low_idx", wl1, 4);
    chk("dut2_wr_low_dat", wl2, 4);
    chk("dut2_cs_low", cs_low, 18);
    chk("dut2_done_edge", done_edge, 19);
    chk("dut2_rdata", rdata2, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop if something wedges the sequence
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
